// File: rtl/hevc_md_mode_buf.sv
// Ping-pong buffer of pre-intra best modes, one bank per LCU.
// Pre-intra fills one bank while intra prediction reads the other.
module hevc_md_mode_buf #(
    parameter int MODE_W    = 6,
    parameter int NUM_MODES = 85
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              md_we,
    input  logic [6:0]        md_waddr,
    input  logic [MODE_W-1:0] md_wdata,
    input  logic              wr_done_i,
    output logic              wr_full_o,
    output logic              rd_ready_o,
    input  logic              rd_start_i,
    output logic              rd_active_o,
    input  logic              rd_ren_i,
    input  logic [1:0]        rd_size_i,
    input  logic [2:0]        rd_x_i,
    input  logic [2:0]        rd_y_i,
    output logic              rd_valid_o,
    output logic [MODE_W-1:0] rd_mode_o,
    input  logic              rd_done_i
);

    logic [MODE_W-1:0] mem [2][NUM_MODES];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;
    logic       rd_active;

    logic       full;
    logic       wr_en;
    logic       wr_acc;
    logic       rd_rel;
    logic       start_acc;
    logic       rd_acc;
    logic [6:0] raddr;
    logic [1:0] cnt_nxt;

    assign full      = (cnt == 2'd2);
    assign wr_en     = md_we && (md_waddr < 7'(NUM_MODES)) && !full;
    assign wr_acc    = wr_done_i && !full;
    assign rd_rel    = rd_done_i && rd_active;
    assign start_acc = rd_start_i && (cnt != 2'd0) && !rd_active;
    assign rd_acc    = rd_ren_i && rd_active;
    assign cnt_nxt   = cnt + {1'b0, wr_acc} - {1'b0, rd_rel};

    assign wr_full_o   = full;
    assign rd_ready_o  = (cnt != 2'd0);
    assign rd_active_o = rd_active;

    // Z-scan address of the requested block within the LCU mode table
    always_comb begin
        raddr = 7'd0;
        unique case (rd_size_i)
            2'd0: raddr = {1'b0, rd_y_i[2], rd_x_i[2], rd_y_i[1],
                           rd_x_i[1], rd_y_i[0], rd_x_i[0]};
            2'd1: raddr = 7'd64 + {3'd0, rd_y_i[2], rd_x_i[2],
                                   rd_y_i[1], rd_x_i[1]};
            2'd2: raddr = 7'd80 + {5'd0, rd_y_i[2], rd_x_i[2]};
            2'd3: raddr = 7'd84;
            default: raddr = 7'd0;
        endcase
    end

    // Mode storage, unreset; writes land in the bank being filled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr][md_waddr] <= md_wdata;
        end
    end

    // Bank bookkeeping: pointers, occupancy and read-open flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            cnt       <= 2'd0;
            rd_active <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (wr_acc) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_rel) begin
                rd_ptr    <= ~rd_ptr;
                rd_active <= 1'b0;
            end else if (start_acc) begin
                rd_active <= 1'b1;
            end
        end
    end

    // One-cycle read port; mode output holds between reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid_o <= 1'b0;
            rd_mode_o  <= '0;
        end else begin
            rd_valid_o <= rd_acc;
            if (rd_acc) begin
                rd_mode_o <= mem[rd_ptr][raddr];
            end
        end
    end

endmodule

// File: tb/tb_hevc_md_mode_buf.sv
// Self-checking bench for hevc_md_mode_buf.
// Expected modes are queued at issue and popped when read data appears.
module tb_hevc_md_mode_buf;

    logic       clk = 1'b0;
    logic       rstn;
    logic       md_we;
    logic [6:0] md_waddr;
    logic [5:0] md_wdata;
    logic       wr_done_i;
    logic       wr_full_o;
    logic       rd_ready_o;
    logic       rd_start_i;
    logic       rd_active_o;
    logic       rd_ren_i;
    logic [1:0] rd_size_i;
    logic [2:0] rd_x_i;
    logic [2:0] rd_y_i;
    logic       rd_valid_o;
    logic [5:0] rd_mode_o;
    logic       rd_done_i;

    int checks = 0;
    int errors = 0;

    logic [5:0] sb[$];
    logic       exp_v;
    logic [5:0] last_m;

    hevc_md_mode_buf #(.MODE_W(6), .NUM_MODES(85)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .md_we      (md_we),
        .md_waddr   (md_waddr),
        .md_wdata   (md_wdata),
        .wr_done_i  (wr_done_i),
        .wr_full_o  (wr_full_o),
        .rd_ready_o (rd_ready_o),
        .rd_start_i (rd_start_i),
        .rd_active_o(rd_active_o),
        .rd_ren_i   (rd_ren_i),
        .rd_size_i  (rd_size_i),
        .rd_x_i     (rd_x_i),
        .rd_y_i     (rd_y_i),
        .rd_valid_o (rd_valid_o),
        .rd_mode_o  (rd_mode_o),
        .rd_done_i  (rd_done_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic status(input string tag, input logic full,
                          input logic rdy, input logic act);
        chk({tag, "_full"}, wr_full_o, full);
        chk({tag, "_ready"}, rd_ready_o, rdy);
        chk({tag, "_active"}, rd_active_o, act);
    endtask

    // Advance one edge, score the read port, then drop all pulses
    task automatic tick();
        @(posedge clk);
        #1;
        chk("rd_valid", rd_valid_o, exp_v);
        if (exp_v) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                last_m = sb.pop_front();
            end
        end
        chk("rd_mode", rd_mode_o, last_m);
        exp_v      = 1'b0;
        md_we      = 1'b0;
        wr_done_i  = 1'b0;
        rd_start_i = 1'b0;
        rd_done_i  = 1'b0;
        rd_ren_i   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] s, input logic [2:0] x,
                      input logic [2:0] y, input logic [5:0] e);
        rd_ren_i  = 1'b1;
        rd_size_i = s;
        rd_x_i    = x;
        rd_y_i    = y;
        exp_v     = 1'b1;
        sb.push_back(e);
        tick();
    endtask

    // Write all 85 entries; optional done (and release+read) on last write
    task automatic fill(input logic [5:0] base, input bit ramp,
                        input bit done, input bit rel,
                        input logic [5:0] rel_m);
        for (int k = 0; k < 85; k++) begin
            md_we    = 1'b1;
            md_waddr = 7'(k);
            md_wdata = ramp ? (6'(k) ^ base) : base;
            if (k == 84 && done) begin
                wr_done_i = 1'b1;
                if (rel) begin
                    rd_done_i = 1'b1;
                    rd_ren_i  = 1'b1;
                    rd_size_i = 2'd3;
                    exp_v     = 1'b1;
                    sb.push_back(rel_m);
                end
            end
            tick();
        end
    endtask

    initial begin
        rstn = 1'b0;
        md_we = 1'b0; md_waddr = '0; md_wdata = '0;
        wr_done_i = 1'b0; rd_start_i = 1'b0; rd_done_i = 1'b0;
        rd_ren_i = 1'b0; rd_size_i = '0; rd_x_i = '0; rd_y_i = '0;
        exp_v = 1'b0;
        last_m = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_mode", rd_mode_o, 0);
        status("rst", 0, 0, 0);
        rstn = 1'b1;
        tick();

        // Ramp fill, done on the last write
        fill(6'h00, 1, 1, 0, 0);
        status("fill1", 0, 1, 0);

        // Read and release while no bank is open: both ignored
        rd_ren_i  = 1'b1;
        rd_done_i = 1'b1;
        tick();
        status("idle", 0, 1, 0);

        rd_start_i = 1'b1;
        tick();
        status("start1", 0, 1, 1);
        rd(2'd0, 3'd3, 3'd5, 6'd39);
        rd(2'd1, 3'd7, 3'd7, 6'd15);
        rd(2'd1, 3'd6, 3'd6, 6'd15);
        rd(2'd2, 3'd4, 3'd0, 6'd17);
        rd(2'd2, 3'd7, 3'd3, 6'd17);
        rd(2'd3, 3'd5, 3'd2, 6'd20);
        rd(2'd0, 3'd0, 3'd7, 6'd42);
        tick();
        rd_done_i = 1'b1;
        tick();
        status("rel1", 0, 0, 0);

        // Ping-pong: two banks, out-of-range write alongside done
        fill(6'h11, 0, 0, 0, 0);
        md_we = 1'b1; md_waddr = 7'd100; md_wdata = 6'h3f;
        wr_done_i = 1'b1;
        tick();
        status("pp1", 0, 1, 0);
        fill(6'h22, 0, 1, 0, 0);
        status("pp2", 1, 1, 0);
        md_we = 1'b1; md_waddr = 7'd0; md_wdata = 6'h33;
        wr_done_i = 1'b1;
        tick();
        status("pp_ign", 1, 1, 0);
        rd_start_i = 1'b1;
        tick();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                rd(2'd0, 3'(x), 3'(y), 6'h11);
        for (int y = 0; y < 8; y += 2)
            for (int x = 0; x < 8; x += 2)
                rd(2'd1, 3'(x), 3'(y), 6'h11);
        rd(2'd3, 3'd0, 3'd0, 6'h11);
        rd_done_i = 1'b1;
        tick();
        status("pp_rel", 0, 1, 0);
        rd_start_i = 1'b1;
        tick();
        rd(2'd0, 3'd0, 3'd0, 6'h22);
        rd(2'd2, 3'd7, 3'd7, 6'h22);

        // Simultaneous done/release, read on the old bank same cycle
        fill(6'h2a, 0, 1, 1, 6'h22);
        status("simul", 0, 1, 0);
        rd_start_i = 1'b1;
        tick();
        rd(2'd3, 3'd1, 3'd1, 6'h2a);

        // Fill the other bank, then reset mid-read with both held
        fill(6'h05, 0, 1, 0, 0);
        status("full2", 1, 1, 1);
        rd_ren_i = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("mrst_valid", rd_valid_o, 0);
        chk("mrst_mode", rd_mode_o, 0);
        status("mrst", 0, 0, 0);
        sb.delete();
        last_m = '0;
        exp_v = 1'b0;
        rd_ren_i = 1'b0;
        tick();
        rstn = 1'b1;
        rd_start_i = 1'b1;
        tick();
        status("post_rst", 0, 0, 0);
        fill(6'h3f, 1, 1, 0, 0);
        status("refill", 0, 1, 0);
        rd_start_i = 1'b1;
        tick();
        rd(2'd0, 3'd3, 3'd5, 6'd24);
        rd(2'd3, 3'd0, 3'd0, 6'd43);
        rd_done_i = 1'b1;
        tick();
        status("end", 0, 0, 0);
        chk("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
